video_fetch: RTL and testbench

Framebuffer read engine for the display path. It answers the display controller's one-cycle word requests (`req`) from a prefetch FIFO and keeps that FIFO topped up with fixed-length burst reads from SDRAM. It sits between the SDRAM arbiter read port and the video timing/pixel-shift block. It restarts at the framebuffer base on every frame-start pulse.

---
 rtl/video_fetch.sv | 162 ++++++++++++++++
 tb/tb_video_fetch.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_fetch.sv
// Framebuffer read engine: serves display word requests from a show-ahead FIFO fed by SDRAM bursts.
// Define VIDEO_FETCH_UNDERFLOW_CNT_EN to build the saturating underflow event counter.
module video_fetch #(
  parameter int unsigned FB_BASE     = 0,
  parameter int unsigned FRAME_WORDS = 153600,
  parameter int unsigned BURST_LEN   = 8,
  parameter int unsigned FIFO_DEPTH  = 32,
  parameter int unsigned ADDR_W      = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_frame_start,
  input  logic              i_req,
  output logic [31:0]       o_viddata,
  output logic              o_mem_rd_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_rd_ack,
  input  logic              i_mem_rd_valid,
  input  logic [31:0]       i_mem_rd_data,
  output logic              o_underflow,
  output logic [15:0]       o_underflow_cnt
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned WW = $clog2(FRAME_WORDS + 1);
  localparam int unsigned KW = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0]     DepthC = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]     BurstC = CW'(BURST_LEN);
  localparam logic [WW-1:0]     BurstW = WW'(BURST_LEN);
  localparam logic [WW-1:0]     FrameW = WW'(FRAME_WORDS);
  localparam logic [KW-1:0]     BurstK = KW'(BURST_LEN);
  localparam logic [KW-1:0]     LastK  = KW'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] BaseA  = ADDR_W'(FB_BASE);
  localparam logic [ADDR_W-1:0] BurstA = ADDR_W'(BURST_LEN);

  typedef enum logic [1:0] {StIdle, StReq, StData, StDrain} state_e;

  state_e            r_state, w_state_next;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [WW-1:0]     r_words_left;
  logic [KW-1:0]     r_keep, r_beat_cnt;
  logic [31:0]       r_fifo [FIFO_DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count;
  logic [31:0]       r_viddata;
  logic              r_underflow;

  logic          w_ack, w_beat, w_wr_en, w_pop, w_under;
  logic [CW-1:0] w_free, w_count_next;
  logic [PW-1:0] w_rptr_next;
  logic [31:0]   w_head_next;

  assign w_free  = DepthC - r_count;
  assign w_ack   = (r_state == StReq) && i_mem_rd_ack;
  assign w_beat  = ((r_state == StData) || (r_state == StDrain)) && i_mem_rd_valid;
  // Beats past the end of the frame and beats coinciding with a flush are dropped.
  assign w_wr_en = (r_state == StData) && i_mem_rd_valid && (r_beat_cnt < r_keep) &&
                   !i_frame_start;
  assign w_pop   = i_req && !i_frame_start && (r_count != '0);
  assign w_under = i_req && !i_frame_start && (r_count == '0);

  assign w_rptr_next  = r_rptr + PW'(w_pop);
  assign w_count_next = r_count + CW'(w_wr_en) - CW'(w_pop);

  always_comb begin
    w_head_next = r_fifo[w_rptr_next];
    if (w_count_next == '0) begin
      w_head_next = '0;
    end else if (w_wr_en && (r_count == CW'(w_pop))) begin
      w_head_next = i_mem_rd_data;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_mem_rd_req = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!i_frame_start && (r_words_left != '0) && (w_free >= BurstC)) w_state_next = StReq;
      end
      StReq: begin
        o_mem_rd_req = 1'b1;
        if (i_mem_rd_ack) w_state_next = i_frame_start ? StDrain : StData;
        else if (i_frame_start) w_state_next = StIdle;
      end
      StData: begin
        if (w_beat && (r_beat_cnt == LastK)) w_state_next = StIdle;
        else if (i_frame_start) w_state_next = StDrain;
      end
      StDrain: begin
        if (w_beat && (r_beat_cnt == LastK)) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_rd_addr    <= BaseA;
      r_words_left <= FrameW;
      r_keep       <= BurstK;
      r_beat_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_ack) r_beat_cnt <= '0;
      else if (w_beat) r_beat_cnt <= r_beat_cnt + KW'(1);
      if (i_frame_start) begin
        r_rd_addr    <= BaseA;
        r_words_left <= FrameW;
      end else if (w_ack) begin
        r_rd_addr    <= r_rd_addr + BurstA;
        r_words_left <= (r_words_left > BurstW) ? r_words_left - BurstW : '0;
        r_keep       <= (r_words_left >= BurstW) ? BurstK : KW'(r_words_left);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_fifo[r_wptr] <= i_mem_rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_viddata   <= '0;
      r_underflow <= 1'b0;
    end else if (i_frame_start) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_viddata   <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + PW'(1);
      r_rptr    <= w_rptr_next;
      r_count   <= w_count_next;
      r_viddata <= w_head_next;
      if (w_under) r_underflow <= 1'b1;
    end
  end

`ifdef VIDEO_FETCH_UNDERFLOW_CNT_EN
  logic [15:0] r_underflow_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_underflow_cnt <= '0;
    else if (w_under && (r_underflow_cnt != 16'hFFFF)) r_underflow_cnt <= r_underflow_cnt + 16'd1;
  end
  assign o_underflow_cnt = r_underflow_cnt;
`else
  assign o_underflow_cnt = 16'h0000;
`endif

  assign o_viddata   = r_viddata;
  assign o_mem_addr  = r_rd_addr;
  assign o_underflow = r_underflow;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_wr_en && !w_pop && (r_count == DepthC)));
endmodule

// File: tb/tb_video_fetch.sv
// Directed bench for video_fetch: a full-frame instance (A) and a 20-word-frame instance (B),
// each driven by a small burst memory model returning 0x1000 + word address.
module tb_video_fetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef VIDEO_FETCH_UNDERFLOW_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic a_rst_n = 1'b0, a_fs = 1'b0, a_req = 1'b0, a_ack = 1'b0, a_valid = 1'b0;
  logic b_rst_n = 1'b0, b_fs = 1'b0, b_req = 1'b0, b_ack = 1'b0, b_valid = 1'b0;
  logic [31:0] a_rdata = '0, b_rdata = '0, a_vid, b_vid;
  logic        a_mreq, b_mreq, a_uf, b_uf;
  logic [23:0] a_maddr, b_maddr;
  logic [15:0] a_ucnt, b_ucnt;

  video_fetch #(.FB_BASE(0), .FRAME_WORDS(153600), .BURST_LEN(8), .FIFO_DEPTH(32),
                .ADDR_W(24)) u_a (
    .clk(clk), .rst_n(a_rst_n), .i_frame_start(a_fs), .i_req(a_req), .o_viddata(a_vid),
    .o_mem_rd_req(a_mreq), .o_mem_addr(a_maddr), .i_mem_rd_ack(a_ack),
    .i_mem_rd_valid(a_valid), .i_mem_rd_data(a_rdata), .o_underflow(a_uf),
    .o_underflow_cnt(a_ucnt));

  video_fetch #(.FB_BASE(0), .FRAME_WORDS(20), .BURST_LEN(8), .FIFO_DEPTH(32),
                .ADDR_W(24)) u_b (
    .clk(clk), .rst_n(b_rst_n), .i_frame_start(b_fs), .i_req(b_req), .o_viddata(b_vid),
    .o_mem_rd_req(b_mreq), .o_mem_addr(b_maddr), .i_mem_rd_ack(b_ack),
    .i_mem_rd_valid(b_valid), .i_mem_rd_data(b_rdata), .o_underflow(b_uf),
    .o_underflow_cnt(b_ucnt));

  // Memory models: ack a pending request at a falling edge, then 8 beats on consecutive edges.
  logic        a_ack_en = 1'b0, b_ack_en = 1'b1;
  int          a_left = 0, b_left = 0, a_idx = 0;
  logic [23:0] a_ptr = '0, b_ptr = '0;
  always @(negedge clk) begin
    a_ack = 1'b0; a_valid = 1'b0; a_rdata = '0;
    if (a_left > 0) begin
      a_valid = 1'b1; a_rdata = 32'h1000 + 32'(a_ptr); a_idx = 8 - a_left;
      a_ptr = a_ptr + 24'd1; a_left = a_left - 1;
    end else if (a_mreq && a_ack_en) begin
      a_ack = 1'b1; a_ptr = a_maddr; a_left = 8;
    end
    b_ack = 1'b0; b_valid = 1'b0; b_rdata = '0;
    if (b_left > 0) begin
      b_valid = 1'b1; b_rdata = 32'h1000 + 32'(b_ptr);
      b_ptr = b_ptr + 24'd1; b_left = b_left - 1;
    end else if (b_mreq && b_ack_en && b_rst_n) begin
      b_ack = 1'b1; b_ptr = b_maddr; b_left = 8;
    end
  end

  logic [23:0] a_acks[$], b_acks[$];
  int a_beats = 0, b_beats = 0;
  always @(posedge clk) begin
    if (a_mreq && a_ack) a_acks.push_back(a_maddr);
    if (a_valid) a_beats++;
    if (b_mreq && b_ack) b_acks.push_back(b_maddr);
    if (b_valid) b_beats++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic        req;
    logic [31:0] vid;
    logic        uf;
  } vec_t;
  vec_t pops[16];

  initial begin
    int b0;
    logic [31:0] got;
    for (int i = 0; i < 8; i++) begin
      pops[2*i]   = '{req: 1'b1, vid: 32'h1000 + 32'(i),     uf: 1'b0};
      pops[2*i+1] = '{req: 1'b0, vid: 32'h1000 + 32'(i + 1), uf: 1'b0};
    end

    // Reset state
    a_ack_en = 1'b1;
    repeat (3) tick();
    check("rst_mreq", 32'(a_mreq), 32'd0);
    check("rst_maddr", 32'(a_maddr), 32'd0);
    check("rst_vid", a_vid, 32'd0);
    check("rst_uf", 32'(a_uf), 32'd0);
    check("rst_ucnt", 32'(a_ucnt), 32'd0);

    // Prefetch after reset release
    a_rst_n = 1'b1;
    tick();
    check("first_req", 32'(a_mreq), 32'd1);
    check("first_addr", 32'(a_maddr), 32'd0);
    tick();
    tick();
    check("beat_to_vid", a_vid, 32'h1000);
    repeat (150) tick();
    check("fill_bursts", 32'(a_acks.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("fill_addr%0d", i), (a_acks.size() > i) ? 32'(a_acks[i]) : 32'hDEAD, 32'(8*i));
    check("fill_beats", 32'(a_beats), 32'd32);
    check("fill_idle", 32'(a_mreq), 32'd0);
    check("fill_head", a_vid, 32'h1000);

    // Table-driven pops, req every other cycle
    for (int i = 0; i < 16; i++) begin
      a_req = pops[i].req;
      check($sformatf("pop%0d_vid", i), a_vid, pops[i].vid);
      check($sformatf("pop%0d_uf", i), 32'(a_uf), 32'(pops[i].uf));
      tick();
    end
    a_req = 1'b0;
    repeat (60) tick();
    check("refill_count", 32'(a_acks.size()), 32'd5);
    check("refill_addr", (a_acks.size() > 4) ? 32'(a_acks[4]) : 32'hDEAD, 32'd32);

    // Flush from IDLE, then underflow with ack withheld
    a_ack_en = 1'b0;
    a_fs = 1'b1;
    tick();
    a_fs = 1'b0;
    check("flush_vid", a_vid, 32'd0);
    check("flush_uf", 32'(a_uf), 32'd0);
    tick();
    check("flush_req", 32'(a_mreq), 32'd1);
    check("flush_base", 32'(a_maddr), 32'd0);
    for (int k = 0; k < 3; k++) begin
      a_req = 1'b1;
      check($sformatf("uf%0d_vid", k), a_vid, 32'd0);
      tick();
      a_req = 1'b0;
      tick();
    end
    check("uf_flag", 32'(a_uf), 32'd1);
    check("uf_cnt", 32'(a_ucnt), CntEn ? 32'd3 : 32'd0);
    check("req_stable", 32'(a_mreq), 32'd1);
    check("addr_stable", 32'(a_maddr), 32'd0);
    a_fs = 1'b1;
    tick();
    a_fs = 1'b0;
    check("fs_uf_clear", 32'(a_uf), 32'd0);
    check("fs_cnt_kept", 32'(a_ucnt), CntEn ? 32'd3 : 32'd0);
    check("req_withdrawn", 32'(a_mreq), 32'd0);
    tick();
    check("req_again", 32'(a_mreq), 32'd1);

    // Simultaneous write and pop at occupancy 1
    a_ack_en = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      tick();
      got = 32'(a_valid);
    end
    check("wp_wait_beat", got, 32'd1);
    tick();
    check("wp_head", a_vid, 32'h1000);
    a_req = 1'b1;
    tick();
    a_req = 1'b0;
    check("wp_order", a_vid, 32'h1001);
    tick();
    a_req = 1'b1;
    check("wp_next", a_vid, 32'h1001);
    tick();
    a_req = 1'b0;
    check("wp_after", a_vid, 32'h1002);
    check("wp_uf", 32'(a_uf), 32'd0);

    // frame_start on beat 3 of an in-flight burst
    got = 0;
    for (int i = 0; i < 300 && got == 0; i++) begin
      tick();
      got = 32'(a_valid && a_idx == 3);
    end
    check("fs_wait_beat3", got, 32'd1);
    a_fs = 1'b1;
    tick();
    a_fs = 1'b0;
    b0 = a_beats;
    check("fs_flush_vid", a_vid, 32'd0);
    check("fs_flush_uf", 32'(a_uf), 32'd0);
    for (int i = 0; i < 30 && !a_mreq; i++) tick();
    check("drain_req", 32'(a_mreq), 32'd1);
    check("drain_beats", 32'(a_beats - b0), 32'd4);
    check("drain_base", 32'(a_maddr), 32'd0);
    tick();
    tick();
    check("refill_head", a_vid, 32'h1000);

    // Short frame: last burst trimmed
    b_rst_n = 1'b1;
    repeat (100) tick();
    check("b_bursts", 32'(b_acks.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("b_addr%0d", i), (b_acks.size() > i) ? 32'(b_acks[i]) : 32'hDEAD, 32'(8*i));
    check("b_beats", 32'(b_beats), 32'd24);
    check("b_idle", 32'(b_mreq), 32'd0);
    for (int i = 0; i < 20; i++) begin
      b_req = 1'b1;
      check($sformatf("b_pop%0d", i), b_vid, 32'h1000 + 32'(i));
      tick();
      b_req = 1'b0;
      tick();
    end
    b_req = 1'b1;
    check("b_empty_vid", b_vid, 32'd0);
    tick();
    b_req = 1'b0;
    check("b_uf", 32'(b_uf), 32'd1);
    repeat (10) tick();
    check("b_no_more_req", 32'(b_acks.size()), 32'd3);
    b_fs = 1'b1;
    tick();
    b_fs = 1'b0;
    check("b_fs_uf", 32'(b_uf), 32'd0);
    tick();
    check("b_restart_req", 32'(b_mreq), 32'd1);
    check("b_restart_addr", 32'(b_maddr), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
